// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with 16x oversampling.
//
// The rx line is brought into the clk domain through a two-flop synchronizer
// that runs every clk.  A four-state FSM (IDLE, START, DATA, STOP) advances only
// on clk cycles where sampleTick is high.  It samples the middle of the start
// bit, then the middle of every data bit and of the stop bit.  A good frame
// loads the holding register (rxData/rxValid).  The consumer clears rxValid
// with rxAck.
//
// Handshake: rxValid stays high from the clk after a good stop bit until the
// first clk in which rxAck is high.  That clear takes effect on the next clk
// edge.  rxAck has no effect while rxValid is low.  If a new byte lands while
// rxValid is still high and rxAck is low, the byte overwrites rxData and
// overrun pulses.
//
// Ports:
//   clk          rising-edge clock for all state
//   rst          synchronous, active-high reset
//   sampleTick   one-clk enable pulse at 16x the baud rate
//   rx           asynchronous serial input, idle high, LSB first
//   rxAck        consumer acknowledge of the held byte
//   rxData       last good received byte
//   rxValid      rxData holds an unacknowledged byte
//   busy         frame reception in progress (START, DATA or STOP)
//   framingError one-clk pulse: stop bit sampled low
//   overrun      one-clk pulse: held byte overwritten while unacknowledged
//   state_dbg    current FSM state, for debug and assertion binding
module uart_rx #(
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sampleTick,
  input  logic       rx,
  input  logic       rxAck,
  output logic [7:0] rxData,
  output logic       rxValid,
  output logic       busy,
  output logic       framingError,
  output logic       overrun,
  output logic [1:0] state_dbg
);

  // Only 16x oversampling is supported.  The tick counter is 4 bits wide.
  localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] MID_TICK  = 4'(OVERSAMPLE / 2 - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t      state;
  logic [3:0]  tick_cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shift_reg;
  logic        rx_meta;
  logic        rx_sync;

  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      tick_cnt     <= '0;
      bit_idx      <= '0;
      shift_reg    <= '0;
      rxData       <= '0;
      rxValid      <= 1'b0;
      busy         <= 1'b0;
      framingError <= 1'b0;
      overrun      <= 1'b0;
      // The line idles high, so preloading ones avoids a fake start bit.
      rx_meta      <= 1'b1;
      rx_sync      <= 1'b1;
    end else begin
      rx_meta      <= rx;
      rx_sync      <= rx_meta;
      framingError <= 1'b0;
      overrun      <= 1'b0;

      // The consumer acknowledge runs every clk.  A good stop bit on the same
      // clk reasserts rxValid further down and overrides this clear.
      if (rxAck && rxValid) begin
        rxValid <= 1'b0;
      end

      if (sampleTick) begin
        case (state)
          IDLE: begin
            if (!rx_sync) begin
              state    <= START;
              tick_cnt <= '0;
              busy     <= 1'b1;
            end
          end

          START: begin
            if (tick_cnt == MID_TICK) begin
              tick_cnt <= '0;
              if (!rx_sync) begin
                // Mid-point of the start bit is still low.  The frame is real.
                state   <= DATA;
                bit_idx <= '0;
              end else begin
                // Glitch or noise: drop back silently.
                state <= IDLE;
                busy  <= 1'b0;
              end
            end else begin
              tick_cnt <= tick_cnt + 4'd1;
            end
          end

          DATA: begin
            if (tick_cnt == LAST_TICK) begin
              tick_cnt           <= '0;
              shift_reg[bit_idx] <= rx_sync;
              if (bit_idx == 3'd7) begin
                state <= STOP;
              end else begin
                bit_idx <= bit_idx + 3'd1;
              end
            end else begin
              tick_cnt <= tick_cnt + 4'd1;
            end
          end

          STOP: begin
            if (tick_cnt == LAST_TICK) begin
              tick_cnt <= '0;
              state    <= IDLE;
              busy     <= 1'b0;
              if (rx_sync) begin
                rxData  <= shift_reg;
                rxValid <= 1'b1;
                // A byte acknowledged on this very clk is not lost.
                overrun <= rxValid && !rxAck;
              end else begin
                framingError <= 1'b1;
              end
            end else begin
              tick_cnt <= tick_cnt + 4'd1;
            end
          end

          default: begin
            state    <= IDLE;
            tick_cnt <= '0;
            busy     <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx.  sampleTick fires every 4th clk, so one bit lasts 64 clk.
// The reference model keeps only the receiver's visible contract: the held
// byte, its valid flag, and how many framingError/overrun pulses each frame
// should produce.
module tb_uart_rx;

  localparam int BIT_CLKS   = 64;
  localparam int FRAME_CLKS = 10 * BIT_CLKS;
  // Clocks from the first tick that sees the start bit to the stop-bit decision:
  // 8 ticks to the middle of the start bit, then 9 bits of 16 ticks, 4 clk each.
  localparam int DECIDE_CLKS = (8 + 9 * 16) * 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       sampleTick;
  logic       rx;
  logic       rxAck;
  logic [7:0] rxData;
  logic       rxValid;
  logic       busy;
  logic       framingError;
  logic       overrun;
  logic [1:0] state_dbg;

  int vectors     = 0;
  int miscompares = 0;

  // Index of the next rising edge; stable whenever the bench looks at it on a negedge.
  int edge_n = 0;

  // Pulse monitor counters (monotonic; tests take deltas).
  int   fe_cycles   = 0;
  int   fe_rises    = 0;
  int   ov_cycles   = 0;
  int   ov_rises    = 0;
  int   busy_cycles = 0;
  logic fe_prev     = 1'b0;
  logic ov_prev     = 1'b0;

  // Reference model of the holding register.
  logic [7:0] model_data;
  logic       model_valid;

  uart_rx #(.OVERSAMPLE(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .sampleTick   (sampleTick),
    .rx           (rx),
    .rxAck        (rxAck),
    .rxData       (rxData),
    .rxValid      (rxValid),
    .busy         (busy),
    .framingError (framingError),
    .overrun      (overrun),
    .state_dbg    (state_dbg)
  );

  // ---------------- clock / reset / tick ----------------
  always #5 clk = ~clk;

  always @(posedge clk) edge_n <= edge_n + 1;

  initial begin
    sampleTick = 1'b0;
    forever begin
      @(negedge clk);
      sampleTick = (edge_n % 4 == 0);
    end
  end

  always @(negedge clk) begin
    fe_prev     <= (framingError === 1'b1);
    ov_prev     <= (overrun === 1'b1);
    fe_cycles   <= fe_cycles + ((framingError === 1'b1) ? 1 : 0);
    fe_rises    <= fe_rises + (((framingError === 1'b1) && !fe_prev) ? 1 : 0);
    ov_cycles   <= ov_cycles + ((overrun === 1'b1) ? 1 : 0);
    ov_rises    <= ov_rises + (((overrun === 1'b1) && !ov_prev) ? 1 : 0);
    busy_cycles <= busy_cycles + ((busy === 1'b1) ? 1 : 0);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, miscompares so far %0d", miscompares);
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  // Drives one 8N1 frame.  With ack_dec set, rxAck is raised for exactly the clk
  // in which the receiver decides the stop bit.  That clk is found from the
  // line timing: the start edge reaches the synchronizer output two edges
  // later, the next tick edge detects it, and the decision comes DECIDE_CLKS
  // later.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                            input bit ack_dec, input int gap);
    logic [9:0] bits;
    int p;
    int dec;
    bits = {stop_bit, b, 1'b0};
    p    = 0;
    dec  = -1;
    for (int i = 0; i < FRAME_CLKS; i++) begin
      @(negedge clk);
      if (i == 0) begin
        p   = edge_n;
        dec = ((p + 2 + 3) / 4) * 4 + DECIDE_CLKS;
      end
      rx = bits[i / BIT_CLKS];
      if (ack_dec) rxAck = (edge_n == dec);
    end
    for (int i = 0; i < gap; i++) begin
      @(negedge clk);
      rx    = 1'b1;
      rxAck = 1'b0;
    end
  endtask

  task automatic pulse_ack();
    @(negedge clk);
    rxAck = 1'b1;
    @(negedge clk);
    rxAck = 1'b0;
    model_valid = 1'b0;
  endtask

  task automatic hold_rx(input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rx = v;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst   = 1'b1;
    rx    = 1'b1;
    rxAck = 1'b0;
    repeat (3) @(negedge clk);
    vectors++; if (rxData !== 8'h00) begin miscompares++; $display("FAIL reset_rxData: got %h expected 00", rxData); end
    vectors++; if (rxValid !== 1'b0) begin miscompares++; $display("FAIL reset_rxValid: got %b expected 0", rxValid); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
    vectors++; if (framingError !== 1'b0) begin miscompares++; $display("FAIL reset_framingError: got %b expected 0", framingError); end
    vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
    rst = 1'b0;
    model_data  = 8'h00;
    model_valid = 1'b0;
    hold_rx(1'b1, 64);
  endtask

  task automatic test_good_frame();
    int fe0, ov0;
    fe0 = fe_cycles; ov0 = ov_cycles;
    send_frame(8'hA5, 1'b1, 1'b0, 96);
    model_data = 8'hA5; model_valid = 1'b1;
    vectors++; if (rxData !== 8'hA5) begin miscompares++; $display("FAIL a5_rxData: got %h expected a5", rxData); end
    vectors++; if (rxValid !== 1'b1) begin miscompares++; $display("FAIL a5_rxValid: got %b expected 1", rxValid); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL a5_busy: got %b expected 0", busy); end
    vectors++; if (fe_cycles - fe0 !== 0) begin miscompares++; $display("FAIL a5_framingError: got %0d pulse clks expected 0", fe_cycles - fe0); end
    vectors++; if (ov_cycles - ov0 !== 0) begin miscompares++; $display("FAIL a5_overrun: got %0d pulse clks expected 0", ov_cycles - ov0); end
  endtask

  task automatic test_false_start();
    int fe0, b0;
    fe0 = fe_cycles; b0 = busy_cycles;
    hold_rx(1'b0, 5 * 4);
    hold_rx(1'b1, 96);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL false_start_busy: got %b expected 0", busy); end
    vectors++; if ((busy_cycles - b0) < 1 || (busy_cycles - b0) > 40) begin miscompares++; $display("FAIL false_start_busy_len: got %0d clks expected 1..40", busy_cycles - b0); end
    vectors++; if (rxValid !== model_valid) begin miscompares++; $display("FAIL false_start_rxValid: got %b expected %b", rxValid, model_valid); end
    vectors++; if (rxData !== model_data) begin miscompares++; $display("FAIL false_start_rxData: got %h expected %h", rxData, model_data); end
    vectors++; if (fe_cycles - fe0 !== 0) begin miscompares++; $display("FAIL false_start_fe: got %0d expected 0", fe_cycles - fe0); end
  endtask

  task automatic test_framing();
    int fe0, fr0, ov0;
    fe0 = fe_cycles; fr0 = fe_rises; ov0 = ov_cycles;
    send_frame(8'h3C, 1'b0, 1'b0, 128);
    vectors++; if (fe_rises - fr0 !== 1) begin miscompares++; $display("FAIL framing_pulses: got %0d expected 1", fe_rises - fr0); end
    vectors++; if (fe_cycles - fe0 !== 1) begin miscompares++; $display("FAIL framing_width: got %0d clks expected 1", fe_cycles - fe0); end
    vectors++; if (rxData !== model_data) begin miscompares++; $display("FAIL framing_rxData: got %h expected %h", rxData, model_data); end
    vectors++; if (rxValid !== model_valid) begin miscompares++; $display("FAIL framing_rxValid: got %b expected %b", rxValid, model_valid); end
    vectors++; if (ov_cycles - ov0 !== 0) begin miscompares++; $display("FAIL framing_overrun: got %0d expected 0", ov_cycles - ov0); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL framing_busy: got %b expected 0", busy); end
  endtask

  task automatic test_back_to_back();
    int ov0, or0;
    pulse_ack();
    ov0 = ov_cycles; or0 = ov_rises;
    send_frame(8'h11, 1'b1, 1'b0, 0);
    send_frame(8'h22, 1'b1, 1'b0, 96);
    model_data = 8'h22; model_valid = 1'b1;
    vectors++; if (rxData !== 8'h22) begin miscompares++; $display("FAIL b2b_rxData: got %h expected 22", rxData); end
    vectors++; if (rxValid !== 1'b1) begin miscompares++; $display("FAIL b2b_rxValid: got %b expected 1", rxValid); end
    vectors++; if (ov_rises - or0 !== 1) begin miscompares++; $display("FAIL b2b_overrun_pulses: got %0d expected 1", ov_rises - or0); end
    vectors++; if (ov_cycles - ov0 !== 1) begin miscompares++; $display("FAIL b2b_overrun_width: got %0d clks expected 1", ov_cycles - ov0); end
  endtask

  task automatic test_ack_coincident();
    int ov0;
    pulse_ack();
    send_frame(8'h11, 1'b1, 1'b0, 96);
    vectors++; if (rxData !== 8'h11) begin miscompares++; $display("FAIL ackc_first_rxData: got %h expected 11", rxData); end
    ov0 = ov_cycles;
    send_frame(8'h22, 1'b1, 1'b1, 96);
    model_data = 8'h22; model_valid = 1'b1;
    vectors++; if (rxData !== 8'h22) begin miscompares++; $display("FAIL ackc_rxData: got %h expected 22", rxData); end
    vectors++; if (rxValid !== 1'b1) begin miscompares++; $display("FAIL ackc_rxValid: got %b expected 1", rxValid); end
    vectors++; if (ov_cycles - ov0 !== 0) begin miscompares++; $display("FAIL ackc_overrun: got %0d expected 0", ov_cycles - ov0); end
  endtask

  task automatic test_break();
    int fe0, fr0;
    fe0 = fe_cycles; fr0 = fe_rises;
    // Long enough for two full frame times; released before the third
    // frame's start-bit check, so that check sees a false start.
    hold_rx(1'b0, 1240);
    hold_rx(1'b1, 128);
    vectors++; if (fe_rises - fr0 !== 2) begin miscompares++; $display("FAIL break_pulses: got %0d expected 2", fe_rises - fr0); end
    vectors++; if (fe_cycles - fe0 !== 2) begin miscompares++; $display("FAIL break_width: got %0d clks expected 2", fe_cycles - fe0); end
    vectors++; if (rxData !== model_data) begin miscompares++; $display("FAIL break_rxData: got %h expected %h", rxData, model_data); end
    vectors++; if (rxValid !== model_valid) begin miscompares++; $display("FAIL break_rxValid: got %b expected %b", rxValid, model_valid); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL break_busy: got %b expected 0", busy); end
  endtask

  task automatic test_reset_mid_frame();
    int fe0, ov0;
    // Start bit plus three data bits of 0xFF, then reset in the middle of DATA.
    hold_rx(1'b0, BIT_CLKS);
    hold_rx(1'b1, 3 * BIT_CLKS);
    fe0 = fe_cycles; ov0 = ov_cycles;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vectors++; if (rxData !== 8'h00) begin miscompares++; $display("FAIL midrst_rxData: got %h expected 00", rxData); end
    vectors++; if (rxValid !== 1'b0) begin miscompares++; $display("FAIL midrst_rxValid: got %b expected 0", rxValid); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    vectors++; if (framingError !== 1'b0 || overrun !== 1'b0) begin miscompares++; $display("FAIL midrst_flags: got fe=%b ov=%b expected 0 0", framingError, overrun); end
    model_data = 8'h00; model_valid = 1'b0;
    hold_rx(1'b1, 5 * BIT_CLKS);
    vectors++; if (fe_cycles - fe0 !== 0 || ov_cycles - ov0 !== 0) begin miscompares++; $display("FAIL midrst_discard: got fe=%0d ov=%0d expected 0 0", fe_cycles - fe0, ov_cycles - ov0); end
    send_frame(8'h5A, 1'b1, 1'b0, 96);
    model_data = 8'h5A; model_valid = 1'b1;
    vectors++; if (rxData !== 8'h5A) begin miscompares++; $display("FAIL midrst_5a_rxData: got %h expected 5a", rxData); end
    vectors++; if (rxValid !== 1'b1) begin miscompares++; $display("FAIL midrst_5a_rxValid: got %b expected 1", rxValid); end
    vectors++; if (ov_cycles - ov0 !== 0) begin miscompares++; $display("FAIL midrst_5a_overrun: got %0d expected 0", ov_cycles - ov0); end
  endtask

  task automatic test_random();
    logic [7:0] b;
    logic       stop_bit;
    int         fe0, ov0, exp_fe, exp_ov;
    for (int n = 0; n < 12; n++) begin
      if ($urandom_range(0, 1) == 1) pulse_ack();
      b        = 8'($urandom_range(0, 255));
      stop_bit = ($urandom_range(0, 4) != 0);
      fe0 = fe_cycles; ov0 = ov_cycles;
      send_frame(b, stop_bit, 1'b0, 128);
      exp_fe = stop_bit ? 0 : 1;
      exp_ov = (stop_bit && model_valid) ? 1 : 0;
      if (stop_bit) begin
        model_data  = b;
        model_valid = 1'b1;
      end
      vectors++; if (rxData !== model_data) begin miscompares++; $display("FAIL rand%0d_rxData: got %h expected %h", n, rxData, model_data); end
      vectors++; if (rxValid !== model_valid) begin miscompares++; $display("FAIL rand%0d_rxValid: got %b expected %b", n, rxValid, model_valid); end
      vectors++; if (fe_cycles - fe0 !== exp_fe) begin miscompares++; $display("FAIL rand%0d_framingError: got %0d expected %0d", n, fe_cycles - fe0, exp_fe); end
      vectors++; if (ov_cycles - ov0 !== exp_ov) begin miscompares++; $display("FAIL rand%0d_overrun: got %0d expected %0d", n, ov_cycles - ov0, exp_ov); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rand%0d_busy: got %b expected 0", n, busy); end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst   = 1'b1;
    rx    = 1'b1;
    rxAck = 1'b0;
    test_reset();
    test_good_frame();
    test_false_start();
    test_framing();
    test_back_to_back();
    test_ack_coincident();
    test_break();
    test_reset_mid_frame();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter OVERSAMPLE, default 16, sampleTick pulses per bit period; only 16 is supported.
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port sampleTick  input  1  one-clk enable pulse at 16x baud rate.
REQ-005 SHALL have port rx  input  1  asynchronous serial line, idle high, 8N1, LSB first.
REQ-006 SHALL have port rxAck  input  1  consumer acknowledge of the held byte.
REQ-007 SHALL have port rxData  output  8  last good received byte.
REQ-008 SHALL have port rxValid  output  1  rxData holds an unacknowledged byte.
REQ-009 SHALL have port busy  output  1  frame reception in progress.
REQ-010 SHALL have port framingError  output  1  one-clk pulse: stop bit sampled low.
REQ-011 SHALL have port overrun  output  1  one-clk pulse: byte overwritten while unacknowledged.

Function
REQ-012 SHALL pass rx through a 2-flop synchronizer clocked every clk, not gated by sampleTick; rxSync is the second flop.
REQ-013 SHALL implement states IDLE, START, DATA, STOP with a 4-bit tick counter and a 3-bit bit index.
REQ-014 SHALL advance state, counter and sampling only on clk cycles with sampleTick=1; rxAck handling is independent of sampleTick.
REQ-015 IDLE: on tick with rxSync=0 -> START, counter=0.
REQ-016 START: on each tick, counter increments; on the tick where counter==7, sample rxSync: 0 -> DATA, counter=0, bitIndex=0; 1 -> IDLE (false start, no flag, no output change).
REQ-017 DATA: on each tick, counter increments; on the tick where counter==15, shift register bit[bitIndex]=rxSync, counter=0; after bitIndex 7 -> STOP, else bitIndex+1.
REQ-018 STOP: on the tick where counter==15, sample rxSync: 1 -> rxData=shift register, rxValid=1; 0 -> framingError=1 for one clk, rxData/rxValid unchanged; both -> IDLE.
REQ-019 Stop-bit decision SHALL be registered: rxValid/framingError assert on the clk after the deciding tick.
REQ-020 busy SHALL be 1 in START, DATA, STOP and 0 in IDLE.
REQ-021 rxAck=1 with rxValid=1 SHALL clear rxValid next clk; rxAck with rxValid=0 SHALL be ignored.
REQ-022 Good stop with rxValid=1 and rxAck=0 SHALL overwrite rxData, keep rxValid=1, pulse overrun one clk.
REQ-023 Good stop coincident with rxAck=1 SHALL load the new byte, keep rxValid=1, no overrun.
REQ-024 A new start bit SHALL be detectable on the first tick after returning to IDLE (back-to-back frames).
REQ-025 rx low continuously (break) SHALL yield framingError per frame time, then re-enter START on the next tick with rxSync low.

Reset
REQ-026 rst=1 SHALL, on next clk edge, set state=IDLE, counter=0, bitIndex=0, shift register=0, rxData=0x00, rxValid=0, busy=0, framingError=0, overrun=0, synchronizer flops=1.
REQ-027 rst SHALL take priority over sampleTick, rxAck and any in-progress frame; a frame interrupted by rst SHALL be discarded with no flag.

Verification (sampleTick every 4 clk, bit = 64 clk)
REQ-028 Frame 0xA5 (start, 1,0,1,0,0,1,0,1, stop) -> rxData=0xA5, rxValid=1, framingError=0, busy low after stop.
REQ-029 rx low 5 ticks then high -> no state beyond START, busy returns 0, rxValid unchanged.
REQ-030 Frame 0x3C with stop bit low -> framingError one-clk pulse, rxData keeps prior value, rxValid unchanged.
REQ-031 Frames 0x11 then 0x22 back-to-back, no rxAck -> rxData=0x22, rxValid=1, overrun one-clk pulse at second load.
REQ-032 rxAck asserted in the same clk as 0x22 loads while 0x11 held -> rxValid=1, rxData=0x22, overrun=0.
REQ-033 rst asserted mid-DATA of 0xFF -> all outputs reset values next clk; following 0x5A frame received correctly.
